// File: rtl/alu_control_pkg.sv
// Shared encodings for the ALU control slice: ALUOp classes, ALU operation
// selects and the funct patterns the decoder recognises.
package alu_control_pkg;

  localparam logic [1:0] ALUOP_I_ALU  = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_MEM    = 2'b11;

  // 3'b111 is reserved and never produced by the decoder.
  typedef enum logic [2:0] {
    CTRL_AND  = 3'b000,
    CTRL_XOR  = 3'b001,
    CTRL_SLL  = 3'b010,
    CTRL_ADD  = 3'b011,
    CTRL_SUB  = 3'b100,
    CTRL_MUL  = 3'b101,
    CTRL_SRAI = 3'b110
  } alu_ctrl_e;

  // R-type patterns are the full {funct7, funct3} concatenation.
  localparam logic [9:0] FUNCT_AND = 10'b0000000_111;
  localparam logic [9:0] FUNCT_XOR = 10'b0000000_100;
  localparam logic [9:0] FUNCT_SLL = 10'b0000000_001;
  localparam logic [9:0] FUNCT_ADD = 10'b0000000_000;
  localparam logic [9:0] FUNCT_SUB = 10'b0100000_000;
  localparam logic [9:0] FUNCT_MUL = 10'b0000001_000;

  localparam logic [2:0] FUNCT3_ADDI = 3'b000;
  localparam logic [2:0] FUNCT3_SRAI = 3'b101;
  localparam logic [6:0] FUNCT7_SRAI = 7'b0100000;

endpackage

// File: rtl/alu_control_decode.sv
// Purely combinational ALU control decode: {funct7, funct3} and ALUOp to an
// ALU operation select plus an "unrecognised encoding" flag.
module alu_control_decode
  import alu_control_pkg::*;
(
  input  logic [9:0] funct_i,
  input  logic [1:0] ALUOp_i,
  output alu_ctrl_e  ctrl,
  output logic       illegal
);

  logic [6:0] funct7;
  logic [2:0] funct3;

  assign funct7 = funct_i[9:3];
  assign funct3 = funct_i[2:0];

  // NOTE: defaults first so every path assigns both outputs; no latch is inferred.
  always_comb begin
    ctrl    = CTRL_ADD;
    illegal = 1'b0;
    unique case (ALUOp_i)
      ALUOP_RTYPE: begin
        unique case (funct_i)
          FUNCT_AND: ctrl = CTRL_AND;
          FUNCT_XOR: ctrl = CTRL_XOR;
          FUNCT_SLL: ctrl = CTRL_SLL;
          FUNCT_ADD: ctrl = CTRL_ADD;
          FUNCT_SUB: ctrl = CTRL_SUB;
          FUNCT_MUL: ctrl = CTRL_MUL;
          default:   illegal = 1'b1;
        endcase
      end
      ALUOP_I_ALU: begin
        // For addi the funct7 field is immediate data, so only funct3 matters.
        if (funct3 == FUNCT3_ADDI) begin
          ctrl = CTRL_ADD;
        end else if (funct3 == FUNCT3_SRAI && funct7 == FUNCT7_SRAI) begin
          ctrl = CTRL_SRAI;
        end else begin
          illegal = 1'b1;
        end
      end
      ALUOP_BRANCH: ctrl = CTRL_SUB;
      ALUOP_MEM:    ctrl = CTRL_ADD;
      default:      ctrl = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// Registered ALU control: one-cycle latency over alu_control_decode.
// Define ALU_CTRL_ILLEGAL_DET_EN to enable illegal_o / illegal_sticky_o.
module alu_control
  import alu_control_pkg::*;
#(
  parameter logic [2:0] RESET_CTRL = 3'b011
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] funct_i,
  input  logic [1:0] ALUOp_i,
  output logic [2:0] ALUCtrl_o,
  output logic       illegal_o,
  output logic       illegal_sticky_o
);

  alu_ctrl_e dec_ctrl;
  logic      dec_illegal;

  alu_control_decode u_decode (
    .funct_i (funct_i),
    .ALUOp_i (ALUOp_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  // NOTE: reset is sampled only at the clock edge (not in the sensitivity
  // list), and state uses non-blocking assignments to avoid ordering races.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ALUCtrl_o <= RESET_CTRL;
    end else begin
      ALUCtrl_o <= dec_ctrl;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_DET_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      illegal_o        <= 1'b0;
      illegal_sticky_o <= 1'b0;
    end else begin
      illegal_o        <= dec_illegal;
      illegal_sticky_o <= illegal_sticky_o | dec_illegal;
    end
  end
`else
  logic unused_dec_illegal;
  assign unused_dec_illegal = dec_illegal;
  assign illegal_o          = 1'b0;
  assign illegal_sticky_o   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_control.sv
// Directed self-checking bench for alu_control; expectations on the illegal
// flags follow whether ALU_CTRL_ILLEGAL_DET_EN is defined.
module tb_alu_control;

`ifdef ALU_CTRL_ILLEGAL_DET_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic [9:0] funct_i;
  logic [1:0] ALUOp_i;
  logic [2:0] ALUCtrl_o;
  logic       illegal_o;
  logic       illegal_sticky_o;

  int n_cmp = 0;
  int n_err = 0;

  alu_control dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .funct_i          (funct_i),
    .ALUOp_i          (ALUOp_i),
    .ALUCtrl_o        (ALUCtrl_o),
    .illegal_o        (illegal_o),
    .illegal_sticky_o (illegal_sticky_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Present inputs, let one rising edge register them, then check 1 ns later.
  task automatic step(input string tag, input logic [9:0] f, input logic [1:0] op,
                      input logic [2:0] e_ctrl, input logic e_ill, input logic e_sticky);
    funct_i = f;
    ALUOp_i = op;
    @(posedge clk_i);
    #1;
    check({tag, " ctrl"},   ALUCtrl_o,        e_ctrl);
    check({tag, " ill"},    illegal_o,        {2'b00, DET & e_ill});
    check({tag, " sticky"}, illegal_sticky_o, {2'b00, DET & e_sticky});
  endtask

  initial begin
    // Reset applied with an illegal decode present: reset must win.
    rst_n_i = 1'b0;
    funct_i = 10'b0000000101;
    ALUOp_i = 2'b10;
    @(posedge clk_i);
    #1;
    check("reset ctrl",   ALUCtrl_o,        3'b011);
    check("reset ill",    illegal_o,        3'b000);
    check("reset sticky", illegal_sticky_o, 3'b000);

    rst_n_i = 1'b1;
    step("srai",     10'b0100000101, 2'b00, 3'b110, 1'b0, 1'b0);
    step("r_and",    10'b0000000111, 2'b10, 3'b000, 1'b0, 1'b0);
    step("r_xor",    10'b0000000100, 2'b10, 3'b001, 1'b0, 1'b0);
    step("r_sll",    10'b0000000001, 2'b10, 3'b010, 1'b0, 1'b0);
    step("r_add",    10'b0000000000, 2'b10, 3'b011, 1'b0, 1'b0);
    step("r_sub",    10'b0100000000, 2'b10, 3'b100, 1'b0, 1'b0);
    step("r_mul",    10'b0000001000, 2'b10, 3'b101, 1'b0, 1'b0);
    step("addi",     10'b1111111000, 2'b00, 3'b011, 1'b0, 1'b0);
    step("branch_a", 10'b1111111111, 2'b01, 3'b100, 1'b0, 1'b0);
    step("branch_b", 10'b0000000101, 2'b01, 3'b100, 1'b0, 1'b0);
    step("mem",      10'b0100000101, 2'b11, 3'b011, 1'b0, 1'b0);

    // Output must not follow the input before the edge.
    funct_i = 10'b0100000000;
    ALUOp_i = 2'b10;
    #1;
    check("latency hold", ALUCtrl_o, 3'b011);
    step("sub_after_hold", 10'b0100000000, 2'b10, 3'b100, 1'b0, 1'b0);

    step("r_illegal",  10'b0000000101, 2'b10, 3'b011, 1'b1, 1'b1);
    step("legal_next", 10'b0000000000, 2'b10, 3'b011, 1'b0, 1'b1);
    step("xor_sticky", 10'b0000000100, 2'b10, 3'b001, 1'b0, 1'b1);
    step("i_bad_f3",   10'b0000000001, 2'b00, 3'b011, 1'b1, 1'b1);
    step("srai_bad_f7",10'b0000001101, 2'b00, 3'b011, 1'b1, 1'b1);
    step("r_sub_f3",   10'b0100000001, 2'b10, 3'b011, 1'b1, 1'b1);
    step("srai_again", 10'b0100000101, 2'b00, 3'b110, 1'b0, 1'b1);

    // Mid-stream reset discards the pending MUL decode and clears sticky.
    rst_n_i = 1'b0;
    step("mid_reset",  10'b0000001000, 2'b10, 3'b011, 1'b0, 1'b0);
    rst_n_i = 1'b1;
    step("post_reset", 10'b0000001000, 2'b10, 3'b101, 1'b0, 1'b0);
    step("post_and",   10'b0000000111, 2'b10, 3'b000, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameter: RESET_CTRL, default 3'b011 (ADD), value ALUCtrl_o takes during reset.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 Port: clk_i, input, 1, rising-edge clock.
REQ-004 Port: rst_n_i, input, 1, synchronous active-low reset.
REQ-005 Port: funct_i, input, 10, {funct7[6:0], funct3[2:0]} of current instruction.
REQ-006 Port: ALUOp_i, input, 2, operation class from main control.
REQ-007 Port: ALUCtrl_o, output, 3, registered ALU operation select.
REQ-008 Port: illegal_o, output, 1, registered: current decode unrecognised.
REQ-009 Port: illegal_sticky_o, output, 1, set on any illegal decode since reset.

Function
REQ-010 ALUCtrl codes SHALL be: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, SRAI 110; 111 reserved, never driven.
REQ-011 ALUOp_i=10 (R-type): funct_i 0000000111->AND, 0000000100->XOR, 0000000001->SLL, 0000000000->ADD, 0100000000->SUB, 0000001000->MUL; any other value->ADD and illegal.
REQ-012 ALUOp_i=00 (I-type ALU): funct3=000->ADD, funct7 ignored (immediate bits); funct3=101 with funct7=0100000->SRAI; anything else->ADD and illegal.
REQ-013 ALUOp_i=01 (branch): SUB regardless of funct_i, never illegal.
REQ-014 ALUOp_i=11 (load/store address): ADD regardless of funct_i, never illegal.
REQ-015 Decode SHALL be purely combinational from funct_i/ALUOp_i; ALUCtrl_o and illegal_o SHALL register it at each rising clk_i edge: latency exactly 1 cycle, no handshake, new decode every cycle.
REQ-016 illegal_sticky_o SHALL set on the edge that registers illegal_o=1 and stay set until reset.
REQ-017 Consecutive differing inputs SHALL produce consecutive differing outputs with no bubble or hold.

Reset
REQ-018 rst_n_i low at a rising edge SHALL force ALUCtrl_o=RESET_CTRL, illegal_o=0, illegal_sticky_o=0, overriding that cycle's decode.
REQ-019 First edge with rst_n_i high SHALL register the then-present inputs; reset asserted mid-stream discards the pending decode.
REQ-020 No asynchronous path from rst_n_i to any output.

Configuration
REQ-021 Macro ALU_CTRL_ILLEGAL_DET_EN: defined -> illegal_o/illegal_sticky_o behave per REQ-011..016.
REQ-022 Macro undefined -> both ports still present, tied constantly 0, no sticky flop; ALUCtrl_o behaviour identical, including ADD fallback.

Structure
REQ-023 Package alu_control_pkg SHALL hold ALUOp constants (I_ALU 00, BRANCH 01, RTYPE 10, MEM 11), the seven ALUCtrl codes, and the six R-type funct constants plus I-type funct3/funct7 constants.
REQ-024 One combinational sub-module alu_control_decode (funct_i, ALUOp_i -> ctrl, illegal) SHALL implement REQ-011..014; alu_control holds only flops, reset, and macro logic.

Verification
REQ-025 Reset: rst_n_i=0 one edge -> ALUCtrl_o=011, illegal_o=0, illegal_sticky_o=0.
REQ-026 SRAI: funct_i=0100000101, ALUOp_i=00 -> ALUCtrl_o=110 one edge later, illegal_o=0.
REQ-027 R-type sweep: 0000000111,0000000100,0000000001,0000000000,0100000000,0000001000 with ALUOp_i=10 on consecutive edges -> 000,001,010,011,100,101 each one cycle delayed.
REQ-028 I-type addi: funct_i=1111111000, ALUOp_i=00 -> 011, illegal_o=0; ALUOp_i=01 any funct -> 100; ALUOp_i=11 any funct -> 011.
REQ-029 Illegal (macro defined): funct_i=0000000101, ALUOp_i=10 -> ALUCtrl_o=011, illegal_o=1, sticky=1; next legal input -> illegal_o=0, sticky stays 1 until rst_n_i=0.
REQ-030 Macro undefined: repeat REQ-029 -> ALUCtrl_o=011, illegal_o=0, illegal_sticky_o=0.
